// File: rtl/dzcpu_useq.sv
// Microcode sequencer: a two-page opcode dispatch table feeds a micro-PC that steps
// through writable microcode RAM, following each uop's flow-control field.
module dzcpu_useq #(
    parameter int OP_W    = 8,
    parameter int UADDR_W = 8,
    parameter int UOP_W   = 13,
    parameter int LA_W    = (UADDR_W > OP_W + 1) ? UADDR_W : OP_W + 1
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [OP_W-1:0]    iMop,
    input  logic               iMopValid,
    output logic               oMopReady,
    input  logic               iFlagZ,
    input  logic               iStall,
    output logic [UOP_W-1:0]   oUop,
    output logic               oUopValid,
    output logic               oIncPc,
    output logic               oFlagUpd,
    output logic               oEof,
    output logic               oFault,
    input  logic               iLoadEn,
    input  logic               iLoadSel,
    input  logic [LA_W-1:0]    iLoadAddr,
    input  logic [UOP_W-1:0]   iLoadData
);

    localparam int UDEPTH = 2 ** UADDR_W;
    localparam int DDEPTH = 2 ** (OP_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, CBWAIT} state_t;

    logic [UOP_W-1:0]   ucode [UDEPTH];
    logic [UADDR_W-1:0] disp  [DDEPTH];

    state_t             state, state_n;
    logic [UADDR_W-1:0] upc, upc_n;
    logic               fault, set_fault;
    logic [UOP_W-1:0]   cur_uop;
    logic [3:0]         flow;
    logic [OP_W:0]      disp_idx;
    logic               inc, fu, end_flow, to_cb;

    assign cur_uop  = ucode[upc];
    assign flow     = cur_uop[UOP_W-1 -: 4];
    assign disp_idx = {(state == CBWAIT), iMop};
    assign oFault   = fault;

    // Tables are writable only while idle so a running flow never sees its code change.
    always_ff @(posedge iClock) begin
        if (iLoadEn && state == IDLE) begin
            if (iLoadSel)
                disp[iLoadAddr[OP_W:0]] <= iLoadData[UADDR_W-1:0];
            else
                ucode[iLoadAddr[UADDR_W-1:0]] <= iLoadData;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state <= IDLE;
            upc   <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            upc   <= upc_n;
            fault <= fault | set_fault;
        end
    end

    always_comb begin
        inc      = 1'b0;
        fu       = 1'b0;
        end_flow = 1'b0;
        to_cb    = 1'b0;
        case (flow)
            4'd1: inc = 1'b1;
            4'd2: end_flow = 1'b1;
            4'd3: begin inc = 1'b1; end_flow = 1'b1; end
            4'd4: begin fu = 1'b1; end_flow = 1'b1; end
            4'd5: begin inc = 1'b1; fu = 1'b1; end_flow = 1'b1; end
            4'd6: begin inc = 1'b1; end_flow = iFlagZ; end
            4'd7: begin inc = 1'b1; end_flow = !iFlagZ; end
            4'd8: begin inc = 1'b1; to_cb = 1'b1; end
            4'd9: fu = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        upc_n     = upc;
        set_fault = 1'b0;
        oMopReady = 1'b0;
        oUopValid = 1'b0;
        oUop      = '0;
        oIncPc    = 1'b0;
        oFlagUpd  = 1'b0;
        oEof      = 1'b0;
        case (state)
            IDLE, CBWAIT: begin
                oMopReady = !iLoadEn;
                if (iMopValid && !iLoadEn) begin
                    upc_n   = disp[disp_idx];
                    state_n = RUN;
                end
            end
            RUN: begin
                oUopValid = 1'b1;
                oUop      = cur_uop;
                if (!iStall) begin
                    oIncPc   = inc;
                    oFlagUpd = fu;
                    oEof     = end_flow;
                    if (end_flow) begin
                        state_n = IDLE;
                    end else if (to_cb) begin
                        state_n = CBWAIT;
                    end else if (upc == '1) begin
                        // Running off the end of microcode RAM aborts the flow.
                        set_fault = 1'b1;
                        state_n   = IDLE;
                        upc_n     = '0;
                    end else begin
                        upc_n = upc + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
- Parametrised microcode sequencer. It replaces the fixed opcode-to-flow LUT, the CB-page LUT and the hard-wired uop ROM with writable tables and a micro-PC state machine.
- It accepts opcode bytes from the fetch stage through a ready/valid handshake and dispatches them through a two-page table (base page and CB page).
- It steps a micro-PC through microcode RAM, honouring the flow-control field of each uop: inc, eof, conditional eof on Z, CB jump.
- It drives the current uop to the datapath, with stall support and a runtime load port.

Parameters:
- OP_W, 8, opcode width.
- UADDR_W, 8, micro-address width; microcode RAM depth is 2^UADDR_W.
- UOP_W, 13, uop width; must satisfy UOP_W >= UADDR_W and UOP_W > 4.
- LA_W, max(UADDR_W, OP_W+1), load address width.

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous, active-low reset.
- iMop  in  OP_W  opcode byte from fetch.
- iMopValid  in  1  iMop valid.
- oMopReady  out  1  sequencer accepts iMop this cycle.
- iFlagZ  in  1  datapath Z flag, used by conditional eof.
- iStall  in  1  hold the current uop (memory/bus busy).
- oUop  out  UOP_W  current uop.
- oUopValid  out  1  oUop is meaningful; it executes in any cycle with oUopValid=1 and iStall=0.
- oIncPc  out  1  advance the architectural PC this cycle.
- oFlagUpd  out  1  datapath latches flags this cycle.
- oEof  out  1  last uop of the flow executes this cycle.
- oFault  out  1  sticky error: micro-PC overflow.
- iLoadEn  in  1  table write strobe.
- iLoadSel  in  1  0 = microcode RAM, 1 = dispatch table.
- iLoadAddr  in  LA_W  write address, zero-extended. For the dispatch table, bit OP_W is the page (1 = CB) and the low bits are the opcode.
- iLoadData  in  UOP_W  write data; the dispatch table uses the low UADDR_W bits.

Behaviour:
- Reset is synchronous and active-low; clock is iClock on the rising edge. Reset values:
  - state = IDLE, uPC = 0, oFault = 0.
  - oUopValid = 0, oUop = 0, oIncPc = 0, oFlagUpd = 0, oEof = 0.
  - Table contents are not reset.
- States: IDLE, RUN, CBWAIT.
- oMopReady = (state == IDLE or state == CBWAIT) and iLoadEn == 0. A load blocks acceptance in the same cycle.
- Loads are only written in IDLE. An iLoadEn pulse in RUN or CBWAIT is ignored and writes nothing.
- IDLE:
  - On iMopValid & oMopReady: uPC <= disp[0][iMop], state <= RUN.
  - Dispatch latency is 1 cycle: the first uop appears in the cycle after acceptance.
- RUN:
  - oUopValid = 1 and oUop = ucode[uPC], read combinationally.
  - F = oUop[UOP_W-1 : UOP_W-4] is the flow field; the remaining bits are opaque to this block.
  - All control outputs are gated by !iStall. With iStall = 1, uPC and state hold and oUop stays stable.
- Flow encodings (next uPC applies when not stalled):
  - 0 OP: uPC + 1.
  - 1 INC: oIncPc = 1; uPC + 1.
  - 2 EOF: oEof = 1; go to IDLE.
  - 3 INC_EOF: oIncPc = 1, oEof = 1; go to IDLE.
  - 4 EOF_FU: oFlagUpd = 1, oEof = 1; go to IDLE.
  - 5 INC_EOF_FU: oIncPc = 1, oFlagUpd = 1, oEof = 1; go to IDLE.
  - 6 INC_EOF_Z: oIncPc = 1. If iFlagZ = 1, oEof = 1 and go to IDLE; else uPC + 1.
  - 7 INC_EOF_NZ: the same with the condition inverted (iFlagZ = 0).
  - 8 JCB: oIncPc = 1; go to CBWAIT.
  - 9 FU: oFlagUpd = 1; uPC + 1.
  - 10–15: treated as OP.
- CBWAIT:
  - oUopValid = 0.
  - On iMopValid & oMopReady: uPC <= disp[1][iMop], state <= RUN.
  - A second JCB inside a CB flow is legal and waits again.
- Overflow:
  - Condition: uPC = 2^UADDR_W - 1, the uop executes, and it does not end the flow (non-eof, or conditional eof not taken).
  - Response: oFault <= 1, state <= IDLE, uPC <= 0; the uop's own outputs still assert that cycle.
  - oFault clears only on reset.
- Back-to-back flows: an opcode offered in the cycle after oEof is accepted immediately, giving one dead cycle between flows.
- Reset asserted mid-flow aborts it; outputs return to reset values the next cycle.

Test Plan:
- Load ucode[5..8] = {INC, INC, OP, INC_EOF} and disp[0][0x31] = 5. Offer 0x31 -> accepted at cycle T. At T+1..T+4, uops 5..8 appear; oIncPc pattern is 1,1,0,1; oEof = 1 at T+4; oMopReady = 1 at T+5.
- CB path: disp[0][0xCB] = 13, ucode[13] = JCB, disp[1][0x7C] = 16, ucode[16] = EOF_FU. Offer 0xCB then 0x7C -> CBWAIT with oUopValid = 0 until the second byte; then uop 16 with oFlagUpd = 1 and oEof = 1.
- Conditional eof: ucode[19] = INC_EOF_Z followed by three OP and an EOF. With iFlagZ = 1 -> oEof at uop 19, so the flow is 1 cycle long. With iFlagZ = 0 -> flow continues to uop 23, for 5 uops in total.
- Stall: assert iStall for 3 cycles on the second uop of a flow -> oUop is held, oIncPc and oEof stay 0 while stalled, and the flow completes 3 cycles late.
- Load and handshake conflicts:
  - iLoadEn together with iMopValid in IDLE -> oMopReady = 0, the write lands, and the opcode is accepted the next cycle using the newly written entry.
  - iLoadEn in RUN -> table unchanged.
- Overflow and reset: UADDR_W = 4 with ucode[15] = OP reached -> oFault = 1 and state returns to IDLE. A later synchronous reset (iReset = 0) clears oFault, and a reset mid-flow returns oUopValid to 0.
